cache_data_array: RTL and testbench



---
 rtl/cache_data_pkg.sv | 29 ++
 rtl/cache_way_ram.sv | 61 ++++++
 rtl/cache_data_array.sv | 98 +++++++++
 tb/tb_cache_data_array.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_data_pkg.sv
// Shared types and sizing helpers for the multi-way cache data store.
package cache_data_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_e;

    localparam int CDA_LINE_WIDTH  = 128;
    localparam int CDA_WORD_WIDTH  = 32;
    localparam int CDA_INDEX_WIDTH = 8;
    localparam int CDA_WAYS        = 2;

    // Distance between consecutive way lanes on rd_data for the default line width.
    localparam int CDA_LANE_OFFSET = CDA_LINE_WIDTH;

    function automatic int calc_words(input int line_width, input int word_width);
        return line_width / word_width;
    endfunction

    function automatic int calc_way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    function automatic int lane_lsb(input int way, input int line_width);
        return way * line_width;
    endfunction

endpackage

// File: rtl/cache_way_ram.sv
// One way of the data store: per-word masked write, whole-line clear port,
// registered read (1 cycle) with write-first merge; no backpressure.
module cache_way_ram
    import cache_data_pkg::*;
#(
    parameter  int LINE_WIDTH  = CDA_LINE_WIDTH,
    parameter  int WORD_WIDTH  = CDA_WORD_WIDTH,
    parameter  int INDEX_WIDTH = CDA_INDEX_WIDTH,
    localparam int WORDS       = calc_words(LINE_WIDTH, WORD_WIDTH),
    localparam int DEPTH       = 2 ** INDEX_WIDTH
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   i_clr_en,
    input  logic [INDEX_WIDTH-1:0] i_clr_index,
    input  logic                   i_wr_en,
    input  logic [INDEX_WIDTH-1:0] i_wr_index,
    input  logic [WORDS-1:0]       i_wr_wmask,
    input  logic [LINE_WIDTH-1:0]  i_wr_data,
    input  logic                   i_rd_en,
    input  logic [INDEX_WIDTH-1:0] i_rd_index,
    output logic [LINE_WIDTH-1:0]  o_rd_data
);

    logic [LINE_WIDTH-1:0] r_mem [DEPTH];
    logic [LINE_WIDTH-1:0] r_rd_data;
    logic [LINE_WIDTH-1:0] w_rd_line;

    always_ff @(posedge clk) begin
        if (i_clr_en) begin
            r_mem[i_clr_index] <= '0;
        end else if (i_wr_en) begin
            for (int k = 0; k < WORDS; k++) begin
                if (i_wr_wmask[k]) begin
                    r_mem[i_wr_index][k*WORD_WIDTH +: WORD_WIDTH] <= i_wr_data[k*WORD_WIDTH +: WORD_WIDTH];
                end
            end
        end
    end

    // Same-index write in this cycle overrides the stored words it masks.
    always_comb begin
        w_rd_line = r_mem[i_rd_index];
        for (int k = 0; k < WORDS; k++) begin
            if (i_wr_en && (i_wr_index == i_rd_index) && i_wr_wmask[k]) begin
                w_rd_line[k*WORD_WIDTH +: WORD_WIDTH] = i_wr_data[k*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= w_rd_line;
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/cache_data_array.sv
// Multi-way cache data store with post-reset clear sequencer (DEPTH cycles busy).
// Read latency 1 cycle, back-to-back capable; requests are ignored while init_busy.
module cache_data_array
    import cache_data_pkg::*;
#(
    parameter  int LINE_WIDTH  = CDA_LINE_WIDTH,
    parameter  int WORD_WIDTH  = CDA_WORD_WIDTH,
    parameter  int INDEX_WIDTH = CDA_INDEX_WIDTH,
    parameter  int WAYS        = CDA_WAYS,
    localparam int WORDS       = calc_words(LINE_WIDTH, WORD_WIDTH),
    localparam int WAY_W       = calc_way_w(WAYS)
) (
    input  logic                       clk,
    input  logic                       resetn,
    output logic                       init_busy,
    input  logic                       rd_en,
    input  logic [INDEX_WIDTH-1:0]     rd_index,
    output logic                       rd_valid,
    output logic [WAYS*LINE_WIDTH-1:0] rd_data,
    input  logic                       wr_en,
    input  logic [WAY_W-1:0]           wr_way,
    input  logic [INDEX_WIDTH-1:0]     wr_index,
    input  logic [WORDS-1:0]           wr_wmask,
    input  logic [LINE_WIDTH-1:0]      wr_data
);

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic [INDEX_WIDTH-1:0] r_clr_cnt;
    logic                   r_rd_valid;
    logic                   w_ready;
    logic                   w_clr_en;
    logic                   w_rd_ok;
    logic                   w_wr_ok;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= INIT;
            r_clr_cnt  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rd_valid <= w_rd_ok;
            if (r_state == INIT) begin
                r_clr_cnt <= r_clr_cnt + INDEX_WIDTH'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clr_en    = 1'b0;
        w_ready     = 1'b0;
        case (r_state)
            INIT: begin
                w_clr_en = resetn;
                if (r_clr_cnt == {INDEX_WIDTH{1'b1}}) begin
                    w_state_nxt = READY;
                end
            end
            READY: begin
                w_ready = 1'b1;
            end
            default: w_state_nxt = INIT;
        endcase
    end

    // Reset cycles must not disturb the array, so user requests are gated by resetn too.
    assign w_rd_ok   = w_ready && resetn && rd_en;
    assign w_wr_ok   = w_ready && resetn && wr_en;
    assign init_busy = (r_state == INIT);
    assign rd_valid  = r_rd_valid;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        logic w_wr_en_way;

        assign w_wr_en_way = w_wr_ok && (wr_way == WAY_W'(w));

        cache_way_ram #(
            .LINE_WIDTH  (LINE_WIDTH),
            .WORD_WIDTH  (WORD_WIDTH),
            .INDEX_WIDTH (INDEX_WIDTH)
        ) u_ram (
            .clk         (clk),
            .resetn      (resetn),
            .i_clr_en    (w_clr_en),
            .i_clr_index (r_clr_cnt),
            .i_wr_en     (w_wr_en_way),
            .i_wr_index  (wr_index),
            .i_wr_wmask  (wr_wmask),
            .i_wr_data   (wr_data),
            .i_rd_en     (w_rd_ok),
            .i_rd_index  (rd_index),
            .o_rd_data   (rd_data[lane_lsb(w, LINE_WIDTH) +: LINE_WIDTH])
        );
    end

endmodule

// File: tb/tb_cache_data_array.sv
// Directed bench for cache_data_array: init sequencing, masked writes, bypass, reset mid-flight.
module tb_cache_data_array;

    localparam int LW = 128;
    localparam int WW = 32;
    localparam int IW = 8;
    localparam int NW = 2;

    logic            clk = 1'b0;
    logic            resetn;
    logic            init_busy;
    logic            rd_en;
    logic [IW-1:0]   rd_index;
    logic            rd_valid;
    logic [NW*LW-1:0] rd_data;
    logic            wr_en;
    logic [0:0]      wr_way;
    logic [IW-1:0]   wr_index;
    logic [3:0]      wr_wmask;
    logic [LW-1:0]   wr_data;

    int checks = 0;
    int passes = 0;

    localparam logic [LW-1:0] D1   = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [LW-1:0] D1P  = 128'h01234567FFFFFFFF_FEDCBA98FFFFFFFF;
    localparam logic [LW-1:0] BYP  = 128'h00000000_00000000_DEADBEEF_00000000;
    localparam logic [LW-1:0] BYPD = 128'h11111111_22222222_DEADBEEF_33333333;

    always #5 clk = ~clk;

    cache_data_array #(
        .LINE_WIDTH  (LW),
        .WORD_WIDTH  (WW),
        .INDEX_WIDTH (IW),
        .WAYS        (NW)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .init_busy (init_busy),
        .rd_en     (rd_en),
        .rd_index  (rd_index),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_way    (wr_way),
        .wr_index  (wr_index),
        .wr_wmask  (wr_wmask),
        .wr_data   (wr_data)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        rd_en    = 1'b0;
        wr_en    = 1'b0;
        rd_index = '0;
        wr_way   = '0;
        wr_index = '0;
        wr_wmask = '0;
        wr_data  = '0;
    endtask

    task automatic do_write(input logic [0:0] way, input logic [IW-1:0] idx,
                            input logic [3:0] mask, input logic [LW-1:0] data);
        wr_en = 1'b1; wr_way = way; wr_index = idx; wr_wmask = mask; wr_data = data;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [IW-1:0] idx);
        rd_en = 1'b1; rd_index = idx;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic count_init(output int n);
        n = 0;
        while (init_busy && n < 400) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        int n;
        idle();
        resetn = 1'b0;
        repeat (3) tick();
        checks++;
        if (init_busy !== 1'b1) $display("FAIL reset_busy: got %b expected 1", init_busy); else passes++;
        checks++;
        if (rd_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", rd_valid); else passes++;
        checks++;
        if (rd_data !== '0) $display("FAIL reset_data: got %h expected 0", rd_data); else passes++;
        resetn = 1'b1;
        count_init(n);
        checks++;
        if (n !== 256) $display("FAIL init_len: got %0d cycles expected 256", n); else passes++;
        do_read(8'h37);
        checks++;
        if (rd_valid !== 1'b1) $display("FAIL rd37_valid: got %b expected 1", rd_valid); else passes++;
        checks++;
        if (rd_data !== '0) $display("FAIL rd37_data: got %h expected 0", rd_data); else passes++;
    endtask

    task automatic test_full_write();
        do_write(1'b1, 8'd5, 4'b1111, D1);
        do_read(8'd5);
        checks++;
        if (rd_valid !== 1'b1) $display("FAIL full_valid: got %b expected 1", rd_valid); else passes++;
        checks++;
        if (rd_data[255:128] !== D1) $display("FAIL full_way1: got %h expected %h", rd_data[255:128], D1); else passes++;
        checks++;
        if (rd_data[127:0] !== '0) $display("FAIL full_way0: got %h expected 0", rd_data[127:0]); else passes++;
        tick();
        checks++;
        if (rd_valid !== 1'b0) $display("FAIL full_valid_drop: got %b expected 0", rd_valid); else passes++;
        checks++;
        if (rd_data !== {D1, 128'h0}) $display("FAIL full_hold: got %h expected %h", rd_data, {D1, 128'h0}); else passes++;
    endtask

    task automatic test_partial_write();
        do_write(1'b1, 8'd5, 4'b0101, {LW{1'b1}});
        do_read(8'd5);
        checks++;
        if (rd_data[255:128] !== D1P) $display("FAIL partial_way1: got %h expected %h", rd_data[255:128], D1P); else passes++;
        checks++;
        if (rd_data[127:0] !== '0) $display("FAIL partial_way0: got %h expected 0", rd_data[127:0]); else passes++;
    endtask

    task automatic test_bypass();
        rd_en = 1'b1; rd_index = 8'd9;
        do_write(1'b0, 8'd9, 4'b0010, BYPD);
        rd_en = 1'b0;
        checks++;
        if (rd_valid !== 1'b1) $display("FAIL byp_valid: got %b expected 1", rd_valid); else passes++;
        checks++;
        if (rd_data[127:0] !== BYP) $display("FAIL byp_way0: got %h expected %h", rd_data[127:0], BYP); else passes++;
        checks++;
        if (rd_data[255:128] !== '0) $display("FAIL byp_way1: got %h expected 0", rd_data[255:128]); else passes++;
        // Read index 5 while writing index 9 of way 1: the two must not interact.
        rd_en = 1'b1; rd_index = 8'd5;
        do_write(1'b1, 8'd9, 4'b1111, D1);
        rd_en = 1'b0;
        checks++;
        if (rd_data !== {D1P, 128'h0}) $display("FAIL indep_rd: got %h expected %h", rd_data, {D1P, 128'h0}); else passes++;
        do_read(8'd9);
        checks++;
        if (rd_data !== {D1, BYP}) $display("FAIL byp_stored: got %h expected %h", rd_data, {D1, BYP}); else passes++;
    endtask

    task automatic test_init_requests();
        int n;
        bit saw_valid;
        idle();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        repeat (50) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        n = 0;
        saw_valid = 1'b0;
        while (init_busy && n < 400) begin
            if (n == 10) begin
                wr_en = 1'b1; wr_way = 1'b0; wr_index = 8'd3; wr_wmask = 4'hF; wr_data = D1;
                rd_en = 1'b1; rd_index = 8'd3;
            end else begin
                idle();
            end
            tick();
            if (rd_valid) saw_valid = 1'b1;
            n++;
        end
        idle();
        checks++;
        if (n !== 256) $display("FAIL init_restart_len: got %0d cycles expected 256", n); else passes++;
        checks++;
        if (saw_valid !== 1'b0) $display("FAIL init_rd_valid: got %b expected 0", saw_valid); else passes++;
        do_read(8'd3);
        checks++;
        if (rd_data !== '0) $display("FAIL init_wr_blocked: got %h expected 0", rd_data); else passes++;
        do_read(8'd5);
        checks++;
        if (rd_data !== '0) $display("FAIL init_cleared5: got %h expected 0", rd_data); else passes++;
    endtask

    task automatic test_reset_inflight();
        int n;
        logic [IW-1:0] idx [3];
        idx[0] = 8'd0; idx[1] = 8'd128; idx[2] = 8'd255;
        do_write(1'b0, 8'd0, 4'hF, D1);
        do_write(1'b1, 8'd128, 4'hF, D1P);
        do_write(1'b0, 8'd255, 4'hF, BYPD);
        do_write(1'b1, 8'd255, 4'hF, D1);
        do_read(8'd128);
        checks++;
        if (rd_data !== {D1P, 128'h0}) $display("FAIL pre_rst_rd: got %h expected %h", rd_data, {D1P, 128'h0}); else passes++;
        rd_en = 1'b1; rd_index = 8'd255;
        resetn = 1'b0;
        tick();
        rd_en = 1'b0;
        resetn = 1'b1;
        checks++;
        if (rd_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", rd_valid); else passes++;
        checks++;
        if (rd_data !== '0) $display("FAIL rst_data: got %h expected 0", rd_data); else passes++;
        count_init(n);
        checks++;
        if (n !== 256) $display("FAIL rst_init_len: got %0d cycles expected 256", n); else passes++;
        for (int i = 0; i < 3; i++) begin
            do_read(idx[i]);
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== '0)
                $display("FAIL post_rst_idx%0d: got valid=%b data=%h expected valid=1 data=0", idx[i], rd_valid, rd_data);
            else passes++;
        end
        // Back-to-back reads over the cleared indices keep rd_valid high.
        rd_en = 1'b1; rd_index = 8'd0;
        tick();
        rd_index = 8'd255;
        tick();
        rd_en = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== '0)
            $display("FAIL b2b_rd: got valid=%b data=%h expected valid=1 data=0", rd_valid, rd_data);
        else passes++;
    endtask

    initial begin
        resetn = 1'b0;
        idle();
        @(negedge clk);
        test_reset();
        test_full_write();
        test_partial_write();
        test_bypass();
        test_init_requests();
        test_reset_inflight();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
